keypad_scanner: RTL

Input-side counterpart of the multiplexed 7-segment display driver. The display driver strobes anodes; this block strobes the columns of a 4x4 key matrix, reads its rows, debounces, and emits one-cycle key events. It sits between the board keypad and the traffic-light core, and supplies operator commands in the same scan-multiplexed style the display uses.

---
 rtl/keypad_scanner_if.sv | 21 ++
 rtl/keypad_scanner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_if.sv
// Keypad matrix bus: column strobes out, row returns in, debounced key events out.
// Ports: row (active-low returns), col (active-low strobes), key_code/key_valid/
//        key_down/multi_key (key event outputs). master = scanner, slave = keypad/consumer.
interface keypad_scanner_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;
  logic       multi_key;

  modport master (
    input  row,
    output col, key_code, key_valid, key_down, multi_key
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_down, multi_key
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 key matrix scanner: strobes columns, samples synchronized rows, debounces per frame.
// Ports: clk, rst_n (async active-low); kp.master carries row in, col strobes and key
//        events (key_code, key_valid pulse, key_down level, multi_key) out.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  keypad_scanner_if.master kp
);

  localparam int            DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]    DEB        = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {IDLE, CONFIRM, PRESSED, RELEASE} state_t;

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] dwell;
  logic [1:0]    col_idx;
  logic [1:0]    acc_n;     // contacts so far this frame, saturating at 2
  logic [3:0]    acc_code;  // code of the first contact this frame
  state_t        state;
  logic [3:0]    cnt;
  logic [3:0]    cand;

  // Combinational view of the frame including the column being sampled now.
  logic       sample, frame_end;
  logic [3:0] hits;
  logic [2:0] col_n, tot;
  logic [1:0] n_next, first_row;
  logic [3:0] code_next;
  logic [3:0] cnt_inc;
  logic       res_none, res_single;

  always_comb begin
    sample    = (dwell == DWELL_LAST);
    frame_end = sample && (col_idx == 2'd3);
    hits      = ~row_sync;
    col_n     = {2'b00, hits[0]} + {2'b00, hits[1]} + {2'b00, hits[2]} + {2'b00, hits[3]};
    tot       = {1'b0, acc_n} + col_n;
    n_next    = (tot >= 3'd2) ? 2'd2 : tot[1:0];
    if (hits[0])      first_row = 2'd0;
    else if (hits[1]) first_row = 2'd1;
    else if (hits[2]) first_row = 2'd2;
    else              first_row = 2'd3;
    // Earlier columns win; within this column the lowest row wins.
    code_next  = (acc_n == 2'd0 && hits != 4'b0000) ? {first_row, col_idx} : acc_code;
    cnt_inc    = cnt + 4'd1;
    res_none   = (n_next == 2'd0);
    res_single = (n_next == 2'd1);
  end

  // Synchronizer, dwell counter, column rotation and frame accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
      dwell    <= '0;
      col_idx  <= 2'd0;
      kp.col   <= 4'b1110;
      acc_n    <= 2'd0;
      acc_code <= 4'd0;
    end else begin
      row_meta <= kp.row;
      row_sync <= row_meta;
      if (sample) begin
        dwell   <= '0;
        col_idx <= col_idx + 2'd1;
        kp.col  <= {kp.col[2:0], kp.col[3]};
        if (frame_end) begin
          acc_n    <= 2'd0;
          acc_code <= 4'd0;
        end else begin
          acc_n    <= n_next;
          acc_code <= code_next;
        end
      end else begin
        dwell <= dwell + DW'(1);
      end
    end
  end

  // Debounce FSM, advanced once per frame; outputs registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      cand         <= 4'd0;
      kp.key_code  <= 4'd0;
      kp.key_valid <= 1'b0;
      kp.key_down  <= 1'b0;
      kp.multi_key <= 1'b0;
    end else begin
      kp.key_valid <= 1'b0;
      if (frame_end) begin
        kp.multi_key <= (n_next == 2'd2);
        case (state)
          IDLE: begin
            if (res_single) begin
              cand <= code_next;
              cnt  <= 4'd1;
              if (DEB == 4'd1) begin
                state        <= PRESSED;
                kp.key_code  <= code_next;
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
              end else begin
                state <= CONFIRM;
              end
            end
          end
          CONFIRM: begin
            if (res_single && code_next == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB) begin
                state        <= PRESSED;
                kp.key_code  <= cand;
                kp.key_valid <= 1'b1;
                kp.key_down  <= 1'b1;
              end
            end else if (res_single) begin
              cand <= code_next;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
            end
          end
          PRESSED: begin
            // Any contact holds the current key; no rollover.
            if (res_none) begin
              cnt <= 4'd1;
              if (DEB == 4'd1) begin
                state       <= IDLE;
                kp.key_down <= 1'b0;
              end else begin
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (res_none) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB) begin
                state       <= IDLE;
                kp.key_down <= 1'b0;
              end
            end else begin
              state <= PRESSED;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
